// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one Avalon-MM flash read master between
// requester 0 (audio sample fetch) and requester 1 (phrase/address table lookup).
// Ports: clock/reset (sync, active-high); reqN/addrN/ackN requester handshakes;
// rdata/err/busy/grant_id status; flash_mem_* Avalon-MM read master.
module flash_read_arbiter #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              grant_id,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [DATA_W-1:0] flash_mem_readdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count starts at 0 on the first WAIT_VALID cycle, so the last allowed
  // cycle is the one holding TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_VALID,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] rdata_q, rdata_nx;
  logic              err_q, err_nx;
  logic              gid_q, gid_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      gid_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      gid_q   <= gid_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    gid_nx   = gid_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the requester not served last.
          gid_nx   = (req0 && req1) ? ~gid_q : req1;
          addr_nx  = gid_nx ? addr1 : addr0;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (!flash_mem_waitrequest) begin
          state_nx = WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        if (flash_mem_readdatavalid) begin
          rdata_nx = flash_mem_readdata;
          err_nx   = 1'b0;
          state_nx = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_nx   = '0;
        err_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign flash_mem_read    = (state == ISSUE);
  assign flash_mem_address = addr_q;
  assign busy              = (state != IDLE);
  assign ack0              = (state == DONE) && !gid_q;
  assign ack1              = (state == DONE) &&  gid_q;
  assign err               = err_q;
  assign rdata             = rdata_q;
  assign grant_id          = gid_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
module tb_flash_read_arbiter;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              ack0, ack1, err, busy, grant_id;
  logic [DATA_W-1:0] rdata;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic              flash_mem_waitrequest = 1'b0;
  logic              flash_mem_readdatavalid = 1'b0;
  logic [DATA_W-1:0] flash_mem_readdata = '0;

  always #5 clock = ~clock;

  flash_read_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req0(req0),
    .addr0(addr0),
    .ack0(ack0),
    .req1(req1),
    .addr1(addr1),
    .ack1(ack1),
    .rdata(rdata),
    .err(err),
    .busy(busy),
    .grant_id(grant_id),
    .flash_mem_read(flash_mem_read),
    .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .flash_mem_readdata(flash_mem_readdata)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] data_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk_exp(input logic id, input logic [31:0] data, input logic e);
    exp_t x;
    x.id = id; x.data = data; x.err = e;
    return x;
  endfunction

  // Flash responder: stalls stall_cfg cycles, returns data on WAIT_VALID cycle vcycle_cfg (0 = never).
  int              stall_cfg = 0;
  int              vcycle_cfg = 1;
  int              stall_left = 0;
  int              read_cycles = 0;
  int              wv_k = 0;
  int              wv_last = 0;
  logic            prev_read = 1'b0;
  logic            in_wait = 1'b0;
  logic            stale_req = 1'b0;
  logic            addr_ok = 1'b1;
  logic [ADDR_W-1:0] first_addr = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (ack0 || ack1) begin
        wv_last = wv_k;
        in_wait = 1'b0;
      end else if (!busy) begin
        in_wait = 1'b0;
      end
      flash_mem_readdatavalid = 1'b0;
      if (flash_mem_read) begin
        if (!prev_read) begin
          stall_left  = stall_cfg;
          read_cycles = 0;
          first_addr  = flash_mem_address;
          addr_ok     = 1'b1;
        end
        read_cycles++;
        if (flash_mem_address !== first_addr) addr_ok = 1'b0;
        if (stall_left > 0) begin
          flash_mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          flash_mem_waitrequest = 1'b0;
          in_wait = 1'b1;
          wv_k    = 0;
        end
      end else begin
        flash_mem_waitrequest = 1'b0;
        if (in_wait) begin
          wv_k++;
          if (vcycle_cfg != 0 && wv_k == vcycle_cfg) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata = (data_q.size() != 0) ? data_q.pop_front() : 32'h0;
          end
        end
      end
      if (stale_req) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'hFFFF_FFFF;
        stale_req               = 1'b0;
      end
      prev_read = flash_mem_read;
    end
  end

  // Scoreboard monitor.
  logic prev_ack = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (ack0 || ack1) begin
        chk("ack_pulse", {31'b0, prev_ack}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("ack_id",   {30'b0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
          chk("grant_id", {31'b0, grant_id}, {31'b0, e.id});
          chk("rdata",    rdata, e.data);
          chk("err",      {31'b0, err}, {31'b0, e.err});
        end
      end
      prev_ack = ack0 | ack1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ack(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(ack0 || ack1) && n < bound);
    chk("ack_seen", 32'(ack0 | ack1), 32'd1);
  endtask

  initial begin
    int n;
    int acks;
    int cyc;

    repeat (2) @(negedge clock);
    chk("rst_read",     32'(flash_mem_read), 32'd0);
    chk("rst_address",  32'(flash_mem_address), 32'd0);
    chk("rst_ack0",     32'(ack0), 32'd0);
    chk("rst_ack1",     32'(ack1), 32'd0);
    chk("rst_err",      32'(err), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_rdata",    rdata, 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd1);

    // Minimum latency: no stall, data on first WAIT_VALID cycle.
    reset = 1'b0;
    stall_cfg = 0; vcycle_cfg = 1;
    data_q.push_back(32'h00C0_FFEE);
    sb_q.push_back(mk_exp(1'b0, 32'h00C0_FFEE, 1'b0));
    addr0 = 23'h000123; req0 = 1'b1;
    wait_ack(20, n);
    req0 = 1'b0;
    chk("min_latency", n, 32'd3);

    // Single read, data two cycles after acceptance; addr0 changes after grant.
    @(negedge clock);
    stall_cfg = 0; vcycle_cfg = 2;
    data_q.push_back(32'hDEAD_BEEF);
    sb_q.push_back(mk_exp(1'b0, 32'hDEAD_BEEF, 1'b0));
    addr0 = 23'h000010; req0 = 1'b1;
    @(negedge clock);
    addr0 = 23'h3ABCDE;
    wait_ack(20, n);
    req0 = 1'b0;
    chk("single_latency", n, 32'd3);
    chk("single_read_cycles", read_cycles, 32'd1);
    chk("single_address", 32'(first_addr), 32'h10);
    chk("single_addr_stable", 32'(addr_ok), 32'd1);
    repeat (3) @(negedge clock);
    chk("rdata_hold", rdata, 32'hDEAD_BEEF);

    // Waitrequest stall on requester 1.
    stall_cfg = 5; vcycle_cfg = 1;
    data_q.push_back(32'h1234_5678);
    sb_q.push_back(mk_exp(1'b1, 32'h1234_5678, 1'b0));
    addr1 = 23'h7FFFFF; req1 = 1'b1;
    wait_ack(40, n);
    req1 = 1'b0;
    chk("stall_latency", n, 32'd8);
    chk("stall_read_cycles", read_cycles, 32'd6);
    chk("stall_address", 32'(first_addr), 32'h7FFFFF);
    chk("stall_addr_stable", 32'(addr_ok), 32'd1);

    // Contention from reset: both requests held high.
    @(negedge clock);
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 23'h000100; addr1 = 23'h000200;
    stall_cfg = 0; vcycle_cfg = 1;
    data_q.push_back(32'hC0DE_0000);
    data_q.push_back(32'hC0DE_0001);
    data_q.push_back(32'hC0DE_0002);
    data_q.push_back(32'hC0DE_0003);
    sb_q.push_back(mk_exp(1'b0, 32'hC0DE_0000, 1'b0));
    sb_q.push_back(mk_exp(1'b1, 32'hC0DE_0001, 1'b0));
    sb_q.push_back(mk_exp(1'b0, 32'hC0DE_0002, 1'b0));
    sb_q.push_back(mk_exp(1'b1, 32'hC0DE_0003, 1'b0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (ack0 || ack1) acks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contention_acks", acks, 32'd4);

    // Timeout: readdatavalid never arrives.
    @(negedge clock);
    stall_cfg = 0; vcycle_cfg = 0;
    sb_q.push_back(mk_exp(1'b0, 32'h0, 1'b1));
    addr0 = 23'h000ABC; req0 = 1'b1;
    wait_ack(30, n);
    req0 = 1'b0;
    chk("timeout_latency", n, 32'd10);
    @(negedge clock);
    chk("timeout_wait_cycles", wv_last, 32'd8);
    stale_req = 1'b1;
    repeat (3) @(negedge clock);
    chk("stale_rdata", rdata, 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);

    // Data arrives on the same cycle the timeout would fire.
    stall_cfg = 0; vcycle_cfg = 8;
    data_q.push_back(32'hA5A5_A5A5);
    sb_q.push_back(mk_exp(1'b0, 32'hA5A5_A5A5, 1'b0));
    addr0 = 23'h000ABD; req0 = 1'b1;
    wait_ack(30, n);
    req0 = 1'b0;
    @(negedge clock);
    chk("simul_wait_cycles", wv_last, 32'd8);

    // Reset during a stalled ISSUE.
    stall_cfg = 50; vcycle_cfg = 1;
    addr0 = 23'h000055; req0 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!flash_mem_read && cyc < 10);
    chk("midrst_read_seen", 32'(flash_mem_read), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clock);
    chk("midrst_read", 32'(flash_mem_read), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", {30'b0, ack1, ack0}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    stall_cfg = 0; vcycle_cfg = 1;
    data_q.push_back(32'h0BAD_F00D);
    sb_q.push_back(mk_exp(1'b0, 32'h0BAD_F00D, 1'b0));
    addr0 = 23'h000077; req0 = 1'b1;
    wait_ack(20, n);
    req0 = 1'b0;
    chk("postrst_latency", n, 32'd3);
    chk("postrst_address", 32'(first_addr), 32'h77);

    repeat (5) @(negedge clock);
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("data_drained", data_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
